// File: rtl/instr_fetch_pkg.sv
// Shared pipeline definitions for the fetch front end, IF/ID and the hazard unit.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEF = 32'h0000_0000;

  // Bubble instruction: IF/ID and the hazard unit treat an all-zero word as a NOP.
  localparam word_t NOP = '0;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  function automatic word_t next_pc(input word_t pc);
    return pc + word_t'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory request/response port between the fetch unit and imem.
interface instr_fetch_if
  import instr_fetch_pkg::*;
();

  logic  imem_req_o;
  word_t imem_addr_o;
  logic  imem_ready_i;
  logic  imem_valid_i;
  word_t imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_valid_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_valid_i,
    output imem_data_i
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO with clear; head is combinational from the read pointer.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && full && !do_pop));

  underflow_check: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty && !clear) || 1'b1);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: owns the PC, issues credit-limited imem requests,
// buffers returned words with their PCs and feeds IF/ID, dropping flushed responses.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter word_t       RESET_PC = RESET_PC_DEF,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          MemStall_i,
  input  logic          flush_i,
  input  word_t         branch_target_i,
  instr_fetch_if.master imem,
  output word_t         instr_o,
  output word_t         PC_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  word_t         pc;
  word_t         pcq_head;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] buf_count;
  logic [CW-1:0] pcq_count;
  logic [SW-1:0] inflight;
  fetch_entry_t  buf_head;
  fetch_entry_t  buf_din;
  logic          advance;
  logic          pop;
  logic          push;
  logic          accept;
  logic          resp;
  logic          buf_valid;

  assign advance   = !stall_i && !MemStall_i && !flush_i;
  assign buf_valid = (buf_count != '0);
  assign pop       = advance && buf_valid;
  assign resp      = imem.imem_valid_i;

  // Credit counts the slot being vacated this cycle so DEPTH=2 sustains one per cycle.
  assign inflight         = SW'(outstanding) + SW'(buf_count) - SW'(pop);
  assign imem.imem_req_o  = !rst_i && !flush_i && (inflight < SW'(DEPTH));
  assign imem.imem_addr_o = pc;
  assign accept           = imem.imem_req_o && imem.imem_ready_i;

  assign push    = resp && !flush_i && (discard == '0);
  assign buf_din = '{instr: imem.imem_data_i, pc: pcq_head};

  assign instr_o = buf_valid ? buf_head.instr : NOP;
  assign PC_o    = buf_valid ? buf_head.pc    : NOP;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      if (flush_i) begin
        // Everything still in flight after this cycle belongs to the squashed path.
        pc      <= branch_target_i;
        discard <= outstanding - CW'(resp);
      end else begin
        if (accept) pc <= next_pc(pc);
        if (resp && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (flush_i),
    .din   (buf_din),
    .head  (buf_head),
    .count (buf_count)
  );

  // Request-PC queue: one entry per outstanding request, popped by every response.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pcq (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (accept),
    .pop   (resp),
    .clear (1'b0),
    .din   (pc),
    .head  (pcq_head),
    .count (pcq_count)
  );

  pcq_tracks_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    pcq_count == outstanding);

  discard_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    discard <= outstanding);

  no_orphan_response: assert property (@(posedge clk_i) disable iff (rst_i)
    !resp || (outstanding != '0));

  credit_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    (SW'(outstanding) + SW'(buf_count)) <= SW'(DEPTH));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic against a queue model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = RESET_PC_DEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        mem_stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] instr;
  logic [31:0] pc_out;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .MemStall_i      (mem_stall),
    .flush_i         (flush),
    .branch_target_i (target),
    .imem            (bus),
    .instr_o         (instr),
    .PC_o            (pc_out)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  req_t        out_q[$];
  ent_t        buf_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] m_pc;

  int errors = 0;
  int checks = 0;

  bit rand_ready = 1'b0;
  bit rand_lat = 1'b0;
  bit hold_resp = 1'b0;
  bit force_ready_low = 1'b0;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    out_q.delete();
    buf_q.delete();
    mem_q.delete();
    m_pc = RPC;
  endtask

  task automatic tick();
    bit          pop, e_req, s_val, s_rdy, s_req, s_flush, push;
    logic [31:0] s_addr, s_target;
    req_t        r;
    s_rdy = force_ready_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    s_val = !rst && !hold_resp && (mem_q.size() > 0) &&
            (rand_lat ? ($urandom_range(0, 1) == 1) : 1'b1);
    bus.imem_ready_i = s_rdy;
    bus.imem_valid_i = s_val;
    bus.imem_data_i  = s_val ? f(mem_q[0]) : $urandom;
    #1;
    pop   = !stall && !mem_stall && !flush && (buf_q.size() > 0);
    e_req = !rst && !flush &&
            (int'(out_q.size()) + int'(buf_q.size()) - int'(pop) < DEPTH);
    chk("imem_req", 32'(bus.imem_req_o), 32'(e_req));
    chk("imem_addr", bus.imem_addr_o, m_pc);
    chk("instr", instr, (buf_q.size() > 0) ? buf_q[0].instr : 32'h0);
    chk("pc", pc_out, (buf_q.size() > 0) ? buf_q[0].pc : 32'h0);
    s_req    = bus.imem_req_o;
    s_addr   = bus.imem_addr_o;
    s_flush  = flush;
    s_target = target;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (s_val) void'(mem_q.pop_front());
      if (s_req && s_rdy) mem_q.push_back(s_addr);
      push = 1'b0;
      if (s_val && (out_q.size() > 0)) begin
        r    = out_q.pop_front();
        push = !r.stale && !s_flush;
      end
      if (pop) void'(buf_q.pop_front());
      if (push) buf_q.push_back('{instr: f(r.pc), pc: r.pc});
      if (s_flush) begin
        buf_q.delete();
        foreach (out_q[i]) out_q[i].stale = 1'b1;
        m_pc = s_target;
      end else if (e_req && s_rdy) begin
        out_q.push_back('{pc: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic wait_pc(input string tag, input logic [31:0] exp);
    int n = 0;
    while ((pc_out == 32'h0) && (n < 20)) begin
      tick();
      n++;
    end
    chk(tag, pc_out, exp);
  endtask

  initial begin
    bus.imem_ready_i = 1'b0;
    bus.imem_valid_i = 1'b0;
    bus.imem_data_i  = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req_o), 32'h0);
    chk("rst_addr", bus.imem_addr_o, RPC);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    repeat (2) tick();

    // Free run: first instruction visible two cycles after the first request.
    rst = 1'b0;
    tick();
    tick();
    chk("first_pc", pc_out, 32'h0);
    chk("first_instr", instr, f(32'h0));
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk("stream_pc", pc_out, 32'(4 * k));
    end

    // Stall while 0x8 is at the head.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_pc", pc_out, 32'h8);
      chk("stall_hold_instr", instr, f(32'h8));
    end
    chk("stall_no_credit", 32'(bus.imem_req_o), 32'h0);
    stall = 1'b0;
    tick();
    chk("resume_c", pc_out, 32'hC);
    tick();
    chk("resume_10", pc_out, 32'h10);

    // Two requests outstanding, then flush to 0x100.
    hold_resp = 1'b1;
    repeat (2) tick();
    flush  = 1'b1;
    target = 32'h100;
    tick();
    flush     = 1'b0;
    hold_resp = 1'b0;
    wait_pc("flush_target", 32'h100);
    tick();
    chk("flush_next", pc_out, 32'h104);
    repeat (3) tick();

    // Flush with MemStall and stall_i high while a response lands.
    flush     = 1'b1;
    mem_stall = 1'b1;
    stall     = 1'b1;
    target    = 32'h100;
    tick();
    flush     = 1'b0;
    mem_stall = 1'b0;
    stall     = 1'b0;
    wait_pc("flush_memstall", 32'h100);
    repeat (3) tick();

    // imem not ready for 4 cycles.
    force_ready_low = 1'b1;
    repeat (4) tick();
    chk("notready_bubble", instr, 32'h0);
    chk("notready_req", 32'(bus.imem_req_o), 32'h1);
    force_ready_low = 1'b0;
    repeat (4) tick();

    // Mid-stream reset.
    rst = 1'b1;
    #1;
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_req", 32'(bus.imem_req_o), 32'h0);
    chk("midrst_addr", bus.imem_addr_o, RPC);
    model_reset();
    tick();
    rst = 1'b0;
    #1;
    chk("restart_req", 32'(bus.imem_req_o), 32'h1);
    chk("restart_addr", bus.imem_addr_o, RPC);
    repeat (4) tick();

    // PC wrap across 2^32.
    flush  = 1'b1;
    target = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    wait_pc("wrap_target", 32'hFFFF_FFF8);
    repeat (6) tick();

    // Randomized traffic with variable memory latency and backpressure.
    rand_ready = 1'b1;
    rand_lat   = 1'b1;
    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(0, 7) == 0);
      mem_stall = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      target    = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    stall     = 1'b0;
    mem_stall = 1'b0;
    flush     = 1'b0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
